// File: rtl/reg_bus_arbiter.sv
// Arbitrates several masters onto the one-hot register access bus, one access per
// transaction (IDLE -> ISSUE -> RESP). Define REG_BUS_ARB_FIXED_PRIO_EN for fixed priority.
module reg_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REG    = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic [NUM_REQ-1:0]              rsp_vld,
    output logic                            rsp_err,
    output logic [REG_WIDTH-1:0]            rsp_rdata,
    output logic [NUM_REG-1:0]              reg_wr_sel,
    output logic                            reg_wr_rd,
    output logic [REG_WIDTH-1:0]            reg_wr_data,
    input  logic [NUM_REG*REG_WIDTH-1:0]    reg_rd_bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [REG_WIDTH-1:0]  wdata_arr [NUM_REQ];
    logic [REG_WIDTH-1:0]  rd_arr    [NUM_REG];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*REG_WIDTH +: REG_WIDTH];
        end
        for (gi = 0; gi < NUM_REG; gi++) begin : g_unpack_rd
            assign rd_arr[gi] = reg_rd_bus[gi*REG_WIDTH +: REG_WIDTH];
        end
    endgenerate

    // Captured transaction
    logic [IDX_W-1:0]      win_reg;
    logic                  wr_reg;
    logic                  err_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    // Registered outputs
    logic [NUM_REG-1:0]    reg_wr_sel_reg;
    logic                  reg_wr_rd_reg;
    logic [REG_WIDTH-1:0]  reg_wr_data_reg;
    logic [NUM_REQ-1:0]    rsp_vld_reg;
    logic                  rsp_err_reg;
    logic [REG_WIDTH-1:0]  rsp_rdata_reg;

`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]      last_winner_reg;
`endif

    // Winner search: rotating start after the last winner, or plain lowest index
    logic                  any_req;
    logic                  found;
    int                    cand;
    logic [IDX_W-1:0]      cand_idx;
    logic [IDX_W-1:0]      win_idx;

    assign any_req = |req_vld;

    always_comb begin
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        win_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_winner_reg) + 1 + k) % NUM_REQ;
`endif
            cand_idx = IDX_W'(cand);
            if (!found && req_vld[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    logic                  win_wr;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [REG_WIDTH-1:0]  win_wdata;
    logic                  win_in_range;
    logic [NUM_REG-1:0]    sel_dec;

    assign win_wr       = req_wr[win_idx];
    assign win_addr     = addr_arr[win_idx];
    assign win_wdata    = wdata_arr[win_idx];
    assign win_in_range = (int'(win_addr) < NUM_REG);

    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_sel_dec
            assign sel_dec[gi] = win_in_range && (win_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Read mux on the captured address; out-of-range addresses select nothing
    logic [REG_WIDTH-1:0]  rd_sel_data;

    always_comb begin
        rd_sel_data = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            if (addr_reg == ADDR_WIDTH'(r)) begin
                rd_sel_data = rd_arr[r];
            end
        end
    end

    // Next state and grant; the grant is gated by rst so every output reads 0 in reset
    logic [NUM_REQ-1:0]    gnt_vec;
    logic                  grant_now;

    always_comb begin
        state_next = state_reg;
        gnt_vec    = '0;
        grant_now  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req && !rst) begin
                    grant_now        = 1'b1;
                    gnt_vec[win_idx] = 1'b1;
                    state_next       = ISSUE;
                end
            end
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg         <= '0;
            wr_reg          <= 1'b0;
            err_reg         <= 1'b0;
            addr_reg        <= '0;
            reg_wr_sel_reg  <= '0;
            reg_wr_rd_reg   <= 1'b0;
            reg_wr_data_reg <= '0;
            rsp_vld_reg     <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
        end else begin
            // Bus and response fields are single-cycle pulses unless reloaded below
            reg_wr_sel_reg  <= '0;
            reg_wr_rd_reg   <= 1'b0;
            reg_wr_data_reg <= '0;
            rsp_vld_reg     <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
            if (grant_now) begin
                win_reg         <= win_idx;
                wr_reg          <= win_wr;
                err_reg         <= !win_in_range;
                addr_reg        <= win_addr;
                reg_wr_sel_reg  <= sel_dec;
                reg_wr_rd_reg   <= win_wr;
                reg_wr_data_reg <= win_wdata;
            end
            if (state_reg == ISSUE) begin
                // Sampled while the select is on the bus: a clear-on-read register
                // only clears afterwards, so this is its pre-clear value
                rsp_vld_reg   <= NUM_REQ'(1) << win_reg;
                rsp_err_reg   <= err_reg;
                rsp_rdata_reg <= (!wr_reg && !err_reg) ? rd_sel_data : '0;
            end
        end
    end

`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_reg <= IDX_W'(NUM_REQ - 1);
        end else if (grant_now) begin
            last_winner_reg <= win_idx;
        end
    end
`endif

    assign req_gnt     = gnt_vec;
    assign rsp_vld     = rsp_vld_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign reg_wr_sel  = reg_wr_sel_reg;
    assign reg_wr_rd   = reg_wr_rd_reg;
    assign reg_wr_data = reg_wr_data_reg;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: register-file environment with one clear-on-read counter,
// directed steps then random traffic checked against a transaction-level model.
module tb_reg_bus_arbiter;

    localparam int N   = 4;
    localparam int R   = 8;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int COR = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_vld, req_wr, req_gnt, rsp_vld;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [R-1:0]      reg_wr_sel;
    logic              reg_wr_rd;
    logic [DW-1:0]     reg_wr_data;
    logic [R*DW-1:0]   reg_rd_bus;

    // Master-side stimulus
    logic [N-1:0]      m_vld;
    logic [N-1:0]      m_wr;
    logic [AW-1:0]     m_addr  [N];
    logic [DW-1:0]     m_wdata [N];

    // Register-file environment
    logic              tb_init;
    logic [DW-1:0]     regs [R];
    logic              cor_rd_strobe;

    // Reference model state
    logic [DW-1:0]     model_regs [R];
    int                last_w;
    int                n_assert = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    assign req_vld = m_vld;
    assign req_wr  = m_wr;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_wdata[i*DW +: DW] = m_wdata[i];
        end
        for (int r = 0; r < R; r++) begin
            reg_rd_bus[r*DW +: DW] = regs[r];
        end
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int r = 0; r < R; r++) regs[r] <= '0;
            cor_rd_strobe <= 1'b0;
        end else begin
            cor_rd_strobe <= reg_wr_sel[COR] && !reg_wr_rd;
            for (int r = 0; r < R; r++) begin
                if (reg_wr_sel[r] && reg_wr_rd) regs[r] <= reg_wr_data;
            end
            if (cor_rd_strobe) regs[COR] <= '0;
        end
    end

    reg_bus_arbiter #(
        .NUM_REQ    (N),
        .NUM_REG    (R),
        .ADDR_WIDTH (AW),
        .REG_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_gnt     (req_gnt),
        .rsp_vld     (rsp_vld),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .reg_wr_sel  (reg_wr_sel),
        .reg_wr_rd   (reg_wr_rd),
        .reg_wr_data (reg_wr_data),
        .reg_rd_bus  (reg_rd_bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(last_w + k) % N]) return (last_w + k) % N;
`endif
        return 0;
    endfunction

    // Called at posedge+1 of an IDLE cycle with requests already driven; returns at posedge+1 of T+3
    task automatic do_txn(input bit keep, output int w);
        logic          wr_e;
        logic [AW-1:0] a_e;
        logic [DW-1:0] d_e;
        logic [DW-1:0] rdata_e;
        bit            inr;
        #1;
        w = model_winner(m_vld);
        chk("req_gnt@T", req_gnt, 64'(1) << w);
        chk("reg_wr_sel@T", reg_wr_sel, 0);
        wr_e = m_wr[w];
        a_e  = m_addr[w];
        d_e  = m_wdata[w];
        inr  = (int'(a_e) < R);
        last_w = w;
        @(posedge clk); #1;
        if (!keep) begin
            m_vld[w]   = 1'b0;
            m_wr[w]    = 1'($urandom_range(0, 1));
            m_addr[w]  = AW'($urandom);
            m_wdata[w] = $urandom;
        end
        #1;
        chk("reg_wr_sel@T+1", reg_wr_sel, inr ? (64'(1) << a_e) : 64'(0));
        if (inr) begin
            chk("reg_wr_rd@T+1", reg_wr_rd, wr_e);
            chk("reg_wr_data@T+1", reg_wr_data, d_e);
        end
        chk("req_gnt@T+1", req_gnt, 0);
        chk("rsp_vld@T+1", rsp_vld, 0);
        chk("cor_strobe@T+1", cor_rd_strobe, 0);
        rdata_e = (!wr_e && inr) ? model_regs[a_e] : '0;
        @(posedge clk); #1;
        chk("rsp_vld@T+2", rsp_vld, 64'(1) << w);
        chk("rsp_err@T+2", rsp_err, !inr);
        chk("rsp_rdata@T+2", rsp_rdata, rdata_e);
        chk("reg_wr_sel@T+2", reg_wr_sel, 0);
        chk("reg_wr_rd@T+2", reg_wr_rd, 0);
        chk("req_gnt@T+2", req_gnt, 0);
        chk("cor_strobe@T+2", cor_rd_strobe, (!wr_e && a_e == AW'(COR)));
        if (wr_e && inr) model_regs[a_e] = d_e;
        if (!wr_e && a_e == AW'(COR)) model_regs[COR] = '0;
        @(posedge clk); #1;
        chk("rsp_vld@T+3", rsp_vld, 0);
        chk("cor_strobe@T+3", cor_rd_strobe, 0);
        $display("txn master=%0d %s addr=%0d wdata=%h rdata=%h err=%0d",
                 w, wr_e ? "WR" : "RD", a_e, d_e, rsp_rdata_seen(rdata_e), !inr);
    endtask

    function automatic logic [DW-1:0] rsp_rdata_seen(input logic [DW-1:0] v);
        return v;
    endfunction

    task automatic issue(input int m, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int w);
        m_vld      = '0;
        m_vld[m]   = 1'b1;
        m_wr[m]    = wr;
        m_addr[m]  = a;
        m_wdata[m] = d;
        do_txn(1'b0, w);
    endtask

    initial begin
        int w;
        rst     = 1'b1;
        tb_init = 1'b1;
        m_vld   = '1;
        m_wr    = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i]  = AW'(i);
            m_wdata[i] = '0;
        end
        for (int r = 0; r < R; r++) model_regs[r] = '0;
        last_w = N - 1;

        // Reset state, with requests pending to show the grant is held off
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_gnt", req_gnt, 0);
        chk("rst rsp_vld", rsp_vld, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst reg_wr_sel", reg_wr_sel, 0);
        chk("rst reg_wr_rd", reg_wr_rd, 0);
        chk("rst reg_wr_data", reg_wr_data, 0);
        m_vld   = '0;
        rst     = 1'b0;
        tb_init = 1'b0;
        @(posedge clk); #1;

        // Directed transactions
        issue(0, 1'b1, 4'd7, 32'hDEAD_BEEF, w);
        issue(3, 1'b1, 4'd2, 32'h0000_1234, w);
        issue(1, 1'b1, 4'd6, 32'h0000_0005, w);
        issue(1, 1'b0, 4'd2, 32'h0, w);
        issue(2, 1'b0, 4'd6, 32'h0, w);
        issue(2, 1'b0, 4'd6, 32'h0, w);
        issue(0, 1'b0, 4'd9, 32'h0, w);
        issue(1, 1'b1, 4'd15, 32'hCAFE_F00D, w);
        issue(3, 1'b0, 4'd7, 32'h0, w);

        // Reset while a write sits in ISSUE: dropped, no response, no write
        m_vld      = 4'b0100;
        m_wr[2]    = 1'b1;
        m_addr[2]  = 4'd3;
        m_wdata[2] = 32'hBAD0_BAD0;
        #1;
        chk("pre-rst req_gnt", req_gnt, 4'b0100);
        @(posedge clk); #1;
        chk("pre-rst reg_wr_sel", reg_wr_sel, 8'h08);
        m_vld = '0;
        rst   = 1'b1;
        #1;
        chk("mid-rst req_gnt", req_gnt, 0);
        chk("mid-rst rsp_vld", rsp_vld, 0);
        chk("mid-rst rsp_err", rsp_err, 0);
        chk("mid-rst rsp_rdata", rsp_rdata, 0);
        chk("mid-rst reg_wr_sel", reg_wr_sel, 0);
        chk("mid-rst reg_wr_rd", reg_wr_rd, 0);
        chk("mid-rst reg_wr_data", reg_wr_data, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        last_w = N - 1;
        @(posedge clk); #1;
        chk("post-rst rsp_vld", rsp_vld, 0);
        chk("post-rst reg_wr_sel", reg_wr_sel, 0);
        @(posedge clk); #1;
        chk("post-rst rsp_vld 2", rsp_vld, 0);
        issue(3, 1'b0, 4'd3, 32'h0, w);

        // All masters requesting continuously
        m_vld = '1;
        for (int i = 0; i < N; i++) begin
            m_wr[i]   = 1'b0;
            m_addr[i] = AW'(i);
        end
        for (int k = 0; k < 5; k++) do_txn(1'b1, w);
        m_vld = '0;

        // Random traffic; ungranted masters keep holding their request
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_vld[i] && $urandom_range(0, 1) == 1) begin
                    m_vld[i]   = 1'b1;
                    m_wr[i]    = 1'($urandom_range(0, 1));
                    m_addr[i]  = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(8, 15))
                                                             : AW'($urandom_range(0, 7));
                    m_wdata[i] = $urandom;
                end
            end
            if (m_vld == '0) begin
                #1;
                chk("idle req_gnt", req_gnt, 0);
                @(posedge clk); #1;
            end else begin
                do_txn(1'b0, w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
